// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate byte cache between the core handshake and memory.
// Optional hit/miss counters are enabled by defining CACHE_STATS_EN.
`ifndef ADDR_BUS_WIDTH
`define ADDR_BUS_WIDTH 16
`endif

module cache_ctrl #(
    parameter int ADDR_W    = `ADDR_BUS_WIDTH,
    parameter int NUM_LINES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [7:0]        hwdata,
    input  logic              hwrite,
    input  logic              hreq,
    output logic              hgrant,
    output logic              hready,
    output logic [7:0]        hrdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_write,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - IDX_W;

    typedef enum logic [1:0] {IDLE, LOOKUP, MEM_RD, MEM_WR} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [7:0]             wdata_q, wdata_d;
    logic                   write_q, write_d;
    logic                   hgrant_q, hgrant_d;
    logic                   hready_q, hready_d;
    logic [7:0]             hrdata_q, hrdata_d;
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
    logic [7:0]             mem_wdata_q, mem_wdata_d;
    logic                   mem_write_q, mem_write_d;
    logic                   mem_req_q, mem_req_d;
    logic [NUM_LINES-1:0]   valid_q, valid_d;

    // Tag/data storage is intentionally unreset; valid bits alone gate hits.
    logic [TAG_W-1:0]       tag_arr_q [NUM_LINES];
    logic [7:0]             data_arr_q [NUM_LINES];

    logic [IDX_W-1:0]       idx;
    logic [TAG_W-1:0]       tag;
    logic                   hit;
    logic                   arr_we;
    logic [7:0]             arr_wdata;

    assign idx = addr_q[IDX_W-1:0];
    assign tag = addr_q[ADDR_W-1:IDX_W];
    assign hit = valid_q[idx] && (tag_arr_q[idx] == tag);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        write_d     = write_q;
        hgrant_d    = 1'b0;
        hready_d    = 1'b0;
        hrdata_d    = hrdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_write_d = mem_write_q;
        mem_req_d   = mem_req_q;
        valid_d     = valid_q;
        arr_we      = 1'b0;
        arr_wdata   = wdata_q;
        case (state_q)
            IDLE: begin
                if (hreq) begin
                    addr_d   = haddr;
                    wdata_d  = hwdata;
                    write_d  = hwrite;
                    hgrant_d = 1'b1;
                    state_d  = LOOKUP;
                end
            end
            LOOKUP: begin
                if (!write_q && hit) begin
                    hrdata_d = data_arr_q[idx];
                    hready_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    mem_req_d   = 1'b1;
                    mem_write_d = write_q;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = wdata_q;
                    state_d     = write_q ? MEM_WR : MEM_RD;
                    // Write-through updates a resident line; a write miss never allocates.
                    if (write_q && hit) begin
                        arr_we    = 1'b1;
                        arr_wdata = wdata_q;
                    end
                end
            end
            MEM_RD: begin
                if (mem_ack) begin
                    arr_we       = 1'b1;
                    arr_wdata    = mem_rdata;
                    valid_d[idx] = 1'b1;
                    hrdata_d     = mem_rdata;
                    hready_d     = 1'b1;
                    mem_req_d    = 1'b0;
                    state_d      = IDLE;
                end
            end
            MEM_WR: begin
                if (mem_ack) begin
                    hready_d    = 1'b1;
                    mem_req_d   = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            hgrant_q    <= 1'b0;
            hready_q    <= 1'b0;
            hrdata_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_write_q <= 1'b0;
            mem_req_q   <= 1'b0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            hgrant_q    <= hgrant_d;
            hready_q    <= hready_d;
            hrdata_q    <= hrdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_write_q <= mem_write_d;
            mem_req_q   <= mem_req_d;
            valid_q     <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (arr_we && !rst) begin
            tag_arr_q[idx]  <= tag;
            data_arr_q[idx] <= arr_wdata;
        end
    end

    assign hgrant    = hgrant_q;
    assign hready    = hready_q;
    assign hrdata    = hrdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_write = mem_write_q;
    assign mem_req   = mem_req_q;

`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == LOOKUP) begin
            if (hit) begin
                if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
            end else begin
                if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl: a behavioural memory answers requests, read results are queued and compared.
// Counter checks are compiled in when CACHE_STATS_EN is defined.
module tb_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] haddr;
    logic [7:0]  hwdata;
    logic        hwrite;
    logic        hreq;
    logic        hgrant;
    logic        hready;
    logic [7:0]  hrdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_write;
    logic        mem_req;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    cache_ctrl #(.ADDR_W(16), .NUM_LINES(16)) dut (
        .clk(clk), .rst(rst), .haddr(haddr), .hwdata(hwdata), .hwrite(hwrite),
        .hreq(hreq), .hgrant(hgrant), .hready(hready), .hrdata(hrdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef CACHE_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_model [int];
    logic [7:0] exp_q [$];
    logic [7:0] obs_q [$];

    // Observations of the last transaction
    int          o_lat;
    int          o_ack_n;
    logic        o_timeout;
    logic        o_seen_mem;
    logic [15:0] o_maddr;
    logic        o_mwr;
    logic [7:0]  o_mwdata;
    logic        o_unstable;
    logic        o_req_at_ready;

    task automatic xact(input logic [15:0] a, input logic w, input logic [7:0] d, input int ack_lat);
        int n;
        int age;
        logic done;
        logic acked;
        n = 0; age = 0; done = 1'b0; acked = 1'b0;
        o_lat = -1; o_ack_n = -1; o_seen_mem = 1'b0; o_unstable = 1'b0;
        o_maddr = '0; o_mwr = 1'b0; o_mwdata = '0; o_req_at_ready = 1'b0;
        haddr = a; hwrite = w; hwdata = d; hreq = 1'b1;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
            mem_ack = 1'b0;
            if (hgrant) hreq = 1'b0;
            if (hready) begin
                done = 1'b1;
                o_lat = n;
                o_req_at_ready = mem_req;
                if (!w) obs_q.push_back(hrdata);
            end else if (mem_req) begin
                if (!o_seen_mem) begin
                    o_seen_mem = 1'b1;
                    o_maddr = mem_addr; o_mwr = mem_write; o_mwdata = mem_wdata;
                end else if (mem_addr !== o_maddr || mem_write !== o_mwr || mem_wdata !== o_mwdata) begin
                    o_unstable = 1'b1;
                end
                age++;
                if (!acked && age > ack_lat) begin
                    acked = 1'b1;
                    o_ack_n = n;
                    mem_ack = 1'b1;
                    mem_rdata = mem_model.exists(int'(mem_addr)) ? mem_model[int'(mem_addr)] : 8'h00;
                    if (mem_write) mem_model[int'(mem_addr)] = mem_wdata;
                end
            end
        end
        hreq = 1'b0;
        mem_ack = 1'b0;
        o_timeout = !done;
    endtask

    task automatic check_read(input string name, input logic exp_miss, input logic [15:0] a);
        logic [7:0] e;
        logic [7:0] g;
        checks++;
        if (o_timeout) begin
            errors++;
            $display("FAIL %s: timeout, hready=0 required=1", name);
            void'(exp_q.pop_front());
            return;
        end
        e = exp_q.pop_front();
        g = obs_q.pop_front();
        if (g !== e) begin
            errors++;
            $display("FAIL %s data: got %02h required %02h", name, g, e);
        end
        checks++;
        if (o_seen_mem !== exp_miss) begin
            errors++;
            $display("FAIL %s mem_req: got %0b required %0b", name, o_seen_mem, exp_miss);
        end
        checks++;
        if (!exp_miss && o_lat != 2) begin
            errors++;
            $display("FAIL %s hit latency: got %0d required 2", name, o_lat);
        end else if (exp_miss && (o_maddr !== a || o_mwr !== 1'b0 || o_lat != o_ack_n + 1 || o_req_at_ready !== 1'b0)) begin
            errors++;
            $display("FAIL %s miss: addr %04h wr %0b lat %0d ack %0d req %0b required addr %04h wr 0 lat ack+1 req 0",
                     name, o_maddr, o_mwr, o_lat, o_ack_n, o_req_at_ready, a);
        end
    endtask

    task automatic do_read(input string name, input logic [15:0] a, input logic [7:0] e, input logic exp_miss, input int lat);
        exp_q.push_back(e);
        xact(a, 1'b0, 8'h00, lat);
        check_read(name, exp_miss, a);
    endtask

    task automatic do_write(input string name, input logic [15:0] a, input logic [7:0] d, input int lat);
        xact(a, 1'b1, d, lat);
        checks++;
        if (o_timeout || !o_seen_mem || o_maddr !== a || o_mwr !== 1'b1 || o_mwdata !== d) begin
            errors++;
            $display("FAIL %s issue: to %0b seen %0b addr %04h wr %0b data %02h required addr %04h wr 1 data %02h",
                     name, o_timeout, o_seen_mem, o_maddr, o_mwr, o_mwdata, a, d);
        end
        checks++;
        if (o_lat != o_ack_n + 1 || o_unstable || o_req_at_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s timing: lat %0d ack %0d unstable %0b req %0b required lat ack+1 stable",
                     name, o_lat, o_ack_n, o_unstable, o_req_at_ready);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++;
        if ({hgrant, hready, hrdata, mem_addr, mem_wdata, mem_write, mem_req} !== '0) begin
            errors++;
            $display("FAIL reset outputs: got %b required 0",
                     {hgrant, hready, hrdata, mem_addr, mem_wdata, mem_write, mem_req});
        end
`ifdef CACHE_STATS_EN
        checks++;
        if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset counters: got %0d/%0d required 0/0", hit_cnt, miss_cnt);
        end
`endif
    endtask

    task automatic test_cold_read();
        do_read("cold_read", 16'h0010, 8'hA5, 1'b1, 1);
        do_read("repeat_read", 16'h0010, 8'hA5, 1'b0, 0);
    endtask

    task automatic test_write_hit();
        do_write("write_hit", 16'h0010, 8'h3C, 2);
        do_read("read_after_write_hit", 16'h0010, 8'h3C, 1'b0, 0);
    endtask

    task automatic test_write_miss();
        do_write("write_miss", 16'h0020, 8'h77, 0);
        do_read("read_after_write_miss", 16'h0020, 8'h77, 1'b1, 3);
    endtask

    task automatic test_conflict();
        do_read("conflict_a", 16'h0005, 8'h11, 1'b1, 0);
        do_read("conflict_b", 16'h0015, 8'h22, 1'b1, 1);
        do_read("conflict_a2", 16'h0005, 8'h11, 1'b1, 2);
    endtask

    task automatic test_back_to_back();
        do_read("b2b_0", 16'h0005, 8'h11, 1'b0, 0);
        do_read("b2b_1", 16'h0020, 8'h77, 1'b0, 0);
        do_read("b2b_2", 16'h0005, 8'h11, 1'b0, 0);
    endtask

    task automatic test_reset_mid();
        int n;
        logic bad;
        n = 0; bad = 1'b0;
        haddr = 16'h0030; hwrite = 1'b0; hreq = 1'b1;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
            if (hgrant) hreq = 1'b0;
        end
        hreq = 1'b0;
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid setup: mem_req %0b required 1", mem_req);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || hready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid after: mem_req %0b hready %0b required 0 0", mem_req, hready);
        end
        mem_ack = 1'b1; mem_rdata = 8'h5A;
        @(negedge clk);
        mem_ack = 1'b0;
        repeat (4) begin
            if (hready !== 1'b0 || mem_req !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL reset_mid late_ack: spurious hready/mem_req got 1 required 0");
        end
        do_read("reset_mid_reread", 16'h0010, 8'h3C, 1'b1, 1);
    endtask

`ifdef CACHE_STATS_EN
    task automatic test_stats();
        apply_reset();
        @(negedge clk);
        mem_model[32'h41] = 8'h41; mem_model[32'h42] = 8'h42; mem_model[32'h43] = 8'h43;
        do_read("stats_r0", 16'h0041, 8'h41, 1'b1, 0);
        do_read("stats_r1", 16'h0042, 8'h42, 1'b1, 0);
        do_read("stats_r2", 16'h0043, 8'h43, 1'b1, 0);
        do_read("stats_r3", 16'h0041, 8'h41, 1'b0, 0);
        do_read("stats_r4", 16'h0042, 8'h42, 1'b0, 0);
        checks++;
        if (hit_cnt !== 16'd2 || miss_cnt !== 16'd3) begin
            errors++;
            $display("FAIL stats: got hit %0d miss %0d required hit 2 miss 3", hit_cnt, miss_cnt);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; hreq = 1'b0; haddr = '0; hwdata = '0; hwrite = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;
        mem_model[32'h10] = 8'hA5;
        mem_model[32'h20] = 8'h99;
        mem_model[32'h05] = 8'h11;
        mem_model[32'h15] = 8'h22;
        mem_model[32'h30] = 8'h5A;
        @(negedge clk);
        test_reset();
        test_cold_read();
        test_write_hit();
        test_write_miss();
        test_conflict();
        test_back_to_back();
        test_reset_mid();
`ifdef CACHE_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
